// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: UART receiver with an elaboration-time frame format, 3-tap majority sampling,
// parity/framing/break/overrun reporting and a ready/valid output register.
module uart_rx_cfg #(
    parameter int CLK       = 51_800_000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pin,
    input  logic                 data_ready,
    output logic                 data_valid,
    output logic [DATA_BITS-1:0] data_byte,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 break_detect,
    output logic                 overrun
);
    localparam int DIV  = (CLK + BAUD / 2) / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);

    if (DIV < 8) begin : g_div_check
        $error("uart_rx_cfg: DIV must be at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_fmt_check
        $error("uart_rx_cfg: illegal frame format");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PAR_BIT, STOP, WAIT_HIGH} state_t;
    state_t state, next;

    logic                 s_meta, s, v0, v1, par_bit, fe_acc;
    logic [CW-1:0]        cnt;
    logic [3:0]           idx;
    logic [DATA_BITS-1:0] word;
    logic                 dec, maj, last_data, last_stop, done, fe_now, pe_now, brk_now;

    assign dec       = cnt == CW'(HALF + 1);
    assign maj       = (v0 & v1) | (v0 & s) | (v1 & s);
    assign last_data = idx == 4'(DATA_BITS - 1);
    assign last_stop = idx == 4'(STOP_BITS - 1);
    assign done      = state == STOP && dec && last_stop;
    assign fe_now    = fe_acc | ~maj;
    assign pe_now    = PARITY != 0 && (^word ^ par_bit ^ (PARITY == 1));
    assign brk_now   = word == '0 && (PARITY == 0 || !par_bit) && fe_now;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) {s_meta, s} <= 2'b11;
        else {s_meta, s} <= {pin, s_meta};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (!s) next = START;
            START:   if (dec) next = maj ? IDLE : DATA;
            DATA:    if (dec && last_data) next = PARITY != 0 ? PAR_BIT : STOP;
            PAR_BIT: if (dec) next = STOP;
            STOP:    if (done) next = fe_now ? WAIT_HIGH : IDLE;
            default: if (s) next = IDLE;
        endcase
    end

    // cnt is held at 0 in IDLE so the first low sample starts the start-bit timing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            idx     <= '0;
            v0      <= 1'b1;
            v1      <= 1'b1;
            word    <= '0;
            par_bit <= 1'b0;
            fe_acc  <= 1'b0;
        end else begin
            cnt <= (state == IDLE || cnt == CW'(DIV - 1)) ? '0 : cnt + 1'b1;
            if (cnt == CW'(HALF - 1)) v0 <= s;
            if (cnt == CW'(HALF)) v1 <= s;
            if (state == IDLE) begin
                idx     <= '0;
                par_bit <= 1'b0;
                fe_acc  <= 1'b0;
            end
            if (dec && state == DATA) begin
                word <= {maj, word[DATA_BITS-1:1]};
                idx  <= last_data ? '0 : idx + 1'b1;
            end
            if (dec && state == PAR_BIT) par_bit <= maj;
            if (dec && state == STOP) begin
                fe_acc <= fe_now;
                idx    <= idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_valid   <= 1'b0;
            data_byte    <= '0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            break_detect <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            break_detect <= done && brk_now;
            overrun      <= done && data_valid && !data_ready;
            if (done && (!data_valid || data_ready)) begin
                data_valid   <= 1'b1;
                data_byte    <= word;
                parity_error <= pe_now;
                frame_error  <= fe_now;
            end else if (data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: scoreboard bench driving 8N1, 8E1 and 7O2 receivers at DIV = 16.
module tb_uart_rx_cfg;
    timeunit 1ns;
    timeprecision 1ps;

    localparam int DIV = 16;
    localparam int LAT = 2 + (1 + 8 + 0 + 1 - 1) * DIV + DIV / 2 + 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] pins = 3'b111;
    logic [2:0] rdy = 3'b111;
    wire  [2:0] dv, pe, fe, brk, ovr;
    wire  [7:0] db0, db1;
    wire  [6:0] db2;
    wire  [8:0] dbo [3];

    assign dbo[0] = {1'b0, db0};
    assign dbo[1] = {1'b0, db1};
    assign dbo[2] = {2'b0, db2};

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int xfers[3] = '{0, 0, 0};
    int brk_cnt[3] = '{0, 0, 0};
    int ovr_cnt[3] = '{0, 0, 0};
    int rise_cyc[3] = '{0, 0, 0};
    int t_fall[3] = '{0, 0, 0};
    logic [2:0] dv_q = 3'b000;
    logic [10:0] q[3][$];

    uart_rx_cfg #(.CLK(16_000_000), .BAUD(1_000_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .reset(reset), .pin(pins[0]), .data_ready(rdy[0]), .data_valid(dv[0]), .data_byte(db0),
        .parity_error(pe[0]), .frame_error(fe[0]), .break_detect(brk[0]), .overrun(ovr[0]));
    uart_rx_cfg #(.CLK(16_000_000), .BAUD(1_000_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .reset(reset), .pin(pins[1]), .data_ready(rdy[1]), .data_valid(dv[1]), .data_byte(db1),
        .parity_error(pe[1]), .frame_error(fe[1]), .break_detect(brk[1]), .overrun(ovr[1]));
    uart_rx_cfg #(.CLK(16_000_000), .BAUD(1_000_000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
        .clk(clk), .reset(reset), .pin(pins[2]), .data_ready(rdy[2]), .data_valid(dv[2]), .data_byte(db2),
        .parity_error(pe[2]), .frame_error(fe[2]), .break_detect(brk[2]), .overrun(ovr[2]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [10:0] e;
        for (int u = 0; u < 3; u++) begin
            if (dv[u] && !dv_q[u]) rise_cyc[u] <= cyc;
            brk_cnt[u] <= brk_cnt[u] + int'(brk[u]);
            ovr_cnt[u] <= ovr_cnt[u] + int'(ovr[u]);
            if (dv[u] && rdy[u]) begin
                xfers[u] <= xfers[u] + 1;
                check($sformatf("u%0d_expected_word", u), 32'(q[u].size() != 0), 32'd1);
                if (q[u].size() != 0) begin
                    e = q[u].pop_front();
                    check($sformatf("u%0d_data", u), 32'(dbo[u]), 32'(e[8:0]));
                    check($sformatf("u%0d_parity_error", u), 32'(pe[u]), 32'(e[9]));
                    check($sformatf("u%0d_frame_error", u), 32'(fe[u]), 32'(e[10]));
                end
            end
        end
        dv_q <= dv;
    end

    task automatic push(input int u, input logic [8:0] d, input logic p, input logic f);
        q[u].push_back({f, p, d});
    endtask

    task automatic bit_out(input int u, input logic b);
        pins[u] = b;
        repeat (DIV) @(posedge clk);
        #1;
    endtask

    task automatic send(input int u, input logic [8:0] d, input int nb, input bit hp, input logic pb,
                        input int ns, input logic [1:0] st);
        @(posedge clk);
        #1;
        t_fall[u] = cyc;
        bit_out(u, 1'b0);
        for (int i = 0; i < nb; i++) bit_out(u, d[i]);
        if (hp) bit_out(u, pb);
        for (int i = 0; i < ns; i++) bit_out(u, st[i]);
        pins[u] = 1'b1;
        repeat (2 * DIV) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int u);
        int n = 0;
        while (q[u].size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("u%0d_drain", u), 32'(q[u].size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_cleared(input string tag);
        for (int u = 0; u < 3; u++) begin
            check($sformatf("%s_u%0d_valid", tag, u), 32'(dv[u]), 32'd0);
            check($sformatf("%s_u%0d_data", tag, u), 32'(dbo[u]), 32'd0);
            check($sformatf("%s_u%0d_flags", tag, u), 32'({pe[u], fe[u], brk[u], ovr[u]}), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, b0, x0, o0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_cleared("reset");
        reset = 1'b0;
        repeat (4) @(posedge clk);

        // 8N1 0xA5 with latency window
        push(0, 9'h0A5, 1'b0, 1'b0);
        send(0, 9'h0A5, 8, 0, 1'b0, 1, 2'b01);
        wait_drain(0);
        lat = rise_cyc[0] - t_fall[0];
        check("u0_latency", (lat >= LAT - 2 && lat <= LAT + 2) ? LAT : lat, LAT);
        check("u0_break_a5", brk_cnt[0], 0);
        check("u0_overrun_a5", ovr_cnt[0], 0);

        // 8E1 0x03 with wrong then right parity bit
        push(1, 9'h003, 1'b1, 1'b0);
        send(1, 9'h003, 8, 1, 1'b1, 1, 2'b01);
        push(1, 9'h003, 1'b0, 1'b0);
        send(1, 9'h003, 8, 1, 1'b0, 1, 2'b01);
        wait_drain(1);

        // 7O2 0x55, valid parity, second stop bit low
        push(2, 9'h055, 1'b0, 1'b1);
        send(2, 9'h055, 7, 1, 1'b1, 2, 2'b01);
        wait_drain(2);
        check("u2_break_55", brk_cnt[2], 0);

        // start-bit glitch on idle line, then 0x3C
        x0 = xfers[0];
        @(posedge clk);
        #1;
        pins[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        pins[0] = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        check("u0_glitch_no_word", xfers[0], x0);
        check("u0_glitch_valid", 32'(dv[0]), 32'd0);
        push(0, 9'h03C, 1'b0, 1'b0);
        send(0, 9'h03C, 8, 0, 1'b0, 1, 2'b01);
        wait_drain(0);

        // overrun while the consumer stalls
        o0 = ovr_cnt[0];
        rdy[0] = 1'b0;
        push(0, 9'h011, 1'b0, 1'b0);
        send(0, 9'h011, 8, 0, 1'b0, 1, 2'b01);
        send(0, 9'h022, 8, 0, 1'b0, 1, 2'b01);
        @(negedge clk);
        check("u0_held_valid", 32'(dv[0]), 32'd1);
        check("u0_held_data", 32'(dbo[0]), 32'h11);
        check("u0_overrun_once", ovr_cnt[0] - o0, 1);
        @(posedge clk);
        #1;
        rdy[0] = 1'b1;
        wait_drain(0);
        check("u0_valid_dropped", 32'(dv[0]), 32'd0);

        // line held low for 30 bit times: one word, one break
        b0 = brk_cnt[0];
        x0 = xfers[0];
        push(0, 9'h000, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        pins[0] = 1'b0;
        repeat (30 * DIV) @(posedge clk);
        #1;
        pins[0] = 1'b1;
        repeat (4 * DIV) @(posedge clk);
        wait_drain(0);
        check("u0_break_once", brk_cnt[0] - b0, 1);
        check("u0_low_one_word", xfers[0] - x0, 1);

        // reset mid-frame while a word is held
        rdy[0] = 1'b0;
        send(0, 9'h05A, 8, 0, 1'b0, 1, 2'b01);
        @(negedge clk);
        check("u0_pre_reset_valid", 32'(dv[0]), 32'd1);
        check("u0_pre_reset_data", 32'(dbo[0]), 32'h5A);
        @(posedge clk);
        #1;
        pins[0] = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        reset = 1'b1;
        pins[0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_cleared("midreset");
        reset = 1'b0;
        rdy[0] = 1'b1;
        x0 = xfers[0];
        repeat (4) @(posedge clk);
        push(0, 9'h07E, 1'b0, 1'b0);
        send(0, 9'h07E, 8, 0, 1'b0, 1, 2'b01);
        wait_drain(0);
        check("u0_after_reset_words", xfers[0] - x0, 1);

        repeat (10) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
